// File: rtl/rps_match_scorer_if.sv
// Verdict handshake between the round judge (master) and the match scorer (slave).
interface rps_match_scorer_if;
  logic       result_valid;
  logic [1:0] result;
  logic       result_ready;

  modport master (output result_valid, output result, input result_ready);
  modport slave  (input result_valid, input result, output result_ready);
endinterface

// File: rtl/rps_match_scorer.sv
// Match scorekeeper for stone-paper-scissors: counts round verdicts, declares a
// winner at WIN_TARGET wins and holds the result until a new match is requested.
module rps_match_scorer #(
  parameter int WIN_TARGET = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_ena,
  input  logic                 i_clear,
  rps_match_scorer_if.slave    if_verdict,
  output logic [3:0]           o_p1_score,
  output logic [3:0]           o_p2_score,
  output logic [3:0]           o_tie_count,
  output logic [3:0]           o_invalid_count,
  output logic [3:0]           o_round_no,
  output logic                 o_match_over,
  output logic [1:0]           o_match_winner,
  output logic                 o_match_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam logic [3:0] L_TARGET = 4'(WIN_TARGET);

  state_t     r_state, w_state_next;
  logic [3:0] r_p1, w_p1_next;
  logic [3:0] r_p2, w_p2_next;
  logic [3:0] r_tie, w_tie_next;
  logic [3:0] r_inv, w_inv_next;
  logic [3:0] r_round, w_round_next;
  logic [1:0] r_winner, w_winner_next;
  logic       r_done, w_done_next;
  logic       w_ready;
  logic       w_accept;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign w_ready  = i_ena & (r_state != S_OVER);
  // clear wins over a verdict arriving in the same cycle
  assign w_accept = w_ready & if_verdict.result_valid & ~i_clear;

  always_comb begin
    w_state_next  = r_state;
    w_p1_next     = r_p1;
    w_p2_next     = r_p2;
    w_tie_next    = r_tie;
    w_inv_next    = r_inv;
    w_round_next  = r_round;
    w_winner_next = r_winner;
    w_done_next   = 1'b0;
    if (i_ena && i_clear) begin
      w_state_next  = S_IDLE;
      w_p1_next     = 4'd0;
      w_p2_next     = 4'd0;
      w_tie_next    = 4'd0;
      w_inv_next    = 4'd0;
      w_round_next  = 4'd0;
      w_winner_next = 2'b00;
    end else if (w_accept) begin
      case (if_verdict.result)
        2'b01: begin
          w_p1_next    = r_p1 + 4'd1;
          w_round_next = sat_inc(r_round);
          if (r_p1 + 4'd1 == L_TARGET) begin
            w_state_next  = S_OVER;
            w_winner_next = 2'b01;
            w_done_next   = 1'b1;
          end else begin
            w_state_next = S_PLAY;
          end
        end
        2'b10: begin
          w_p2_next    = r_p2 + 4'd1;
          w_round_next = sat_inc(r_round);
          if (r_p2 + 4'd1 == L_TARGET) begin
            w_state_next  = S_OVER;
            w_winner_next = 2'b10;
            w_done_next   = 1'b1;
          end else begin
            w_state_next = S_PLAY;
          end
        end
        2'b00: begin
          w_tie_next   = sat_inc(r_tie);
          w_round_next = sat_inc(r_round);
          w_state_next = S_PLAY;
        end
        default: begin
          // invalid verdicts are tallied but never advance the match
          w_inv_next = sat_inc(r_inv);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_p1     <= 4'd0;
      r_p2     <= 4'd0;
      r_tie    <= 4'd0;
      r_inv    <= 4'd0;
      r_round  <= 4'd0;
      r_winner <= 2'b00;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_p1     <= w_p1_next;
      r_p2     <= w_p2_next;
      r_tie    <= w_tie_next;
      r_inv    <= w_inv_next;
      r_round  <= w_round_next;
      r_winner <= w_winner_next;
      r_done   <= w_done_next;
    end
  end

  assign if_verdict.result_ready = w_ready;
  assign o_p1_score      = r_p1;
  assign o_p2_score      = r_p2;
  assign o_tie_count     = r_tie;
  assign o_invalid_count = r_inv;
  assign o_round_no      = r_round;
  assign o_match_over    = (r_state == S_OVER);
  assign o_match_winner  = r_winner;
  assign o_match_done    = r_done;

endmodule

// File: tb/tb_rps_match_scorer.sv
// Bench for rps_match_scorer: two instances (targets 3 and 1) share stimulus and
// are checked each cycle against a per-match tally model.
module tb_rps_match_scorer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       clear;

  rps_match_scorer_if u_if0 ();
  rps_match_scorer_if u_if1 ();

  logic [3:0] p1_0, p2_0, tie_0, inv_0, rnd_0;
  logic [3:0] p1_1, p2_1, tie_1, inv_1, rnd_1;
  logic       over_0, done_0, over_1, done_1;
  logic [1:0] win_0, win_1;

  rps_match_scorer #(.WIN_TARGET(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_ena(ena), .i_clear(clear), .if_verdict(u_if0),
    .o_p1_score(p1_0), .o_p2_score(p2_0), .o_tie_count(tie_0),
    .o_invalid_count(inv_0), .o_round_no(rnd_0), .o_match_over(over_0),
    .o_match_winner(win_0), .o_match_done(done_0)
  );

  rps_match_scorer #(.WIN_TARGET(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_ena(ena), .i_clear(clear), .if_verdict(u_if1),
    .o_p1_score(p1_1), .o_p2_score(p2_1), .o_tie_count(tie_1),
    .o_invalid_count(inv_1), .o_round_no(rnd_1), .o_match_over(over_1),
    .o_match_winner(win_1), .o_match_done(done_1)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int txn = 0;

  // match tallies per instance
  int m_target [2] = '{3, 1};
  int m_p1 [2], m_p2 [2], m_tie [2], m_inv [2], m_rnd [2], m_win [2];
  bit m_over [2], m_done [2];

  function automatic int min15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_p1[k] = 0; m_p2[k] = 0; m_tie[k] = 0; m_inv[k] = 0; m_rnd[k] = 0;
      m_win[k] = 0; m_over[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_step(input bit en, input bit v, input int r, input bit c);
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0;
      if (!en) continue;
      if (c) begin
        m_p1[k] = 0; m_p2[k] = 0; m_tie[k] = 0; m_inv[k] = 0; m_rnd[k] = 0;
        m_win[k] = 0; m_over[k] = 0;
      end else if (v && !m_over[k]) begin
        if (r == 3) begin
          m_inv[k] = min15(m_inv[k] + 1);
        end else begin
          m_rnd[k] = min15(m_rnd[k] + 1);
          if (r == 0) m_tie[k] = min15(m_tie[k] + 1);
          if (r == 1) m_p1[k]++;
          if (r == 2) m_p2[k]++;
          if (m_p1[k] == m_target[k] || m_p2[k] == m_target[k]) begin
            m_over[k] = 1;
            m_done[k] = 1;
            m_win[k]  = (m_p1[k] == m_target[k]) ? 1 : 2;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input int k, input logic [3:0] p1, input logic [3:0] p2,
                          input logic [3:0] tie, input logic [3:0] inv,
                          input logic [3:0] rnd, input logic over,
                          input logic [1:0] win, input logic done);
    chk($sformatf("u%0d_p1", k), 8'(p1), 8'(m_p1[k]));
    chk($sformatf("u%0d_p2", k), 8'(p2), 8'(m_p2[k]));
    chk($sformatf("u%0d_tie", k), 8'(tie), 8'(m_tie[k]));
    chk($sformatf("u%0d_inv", k), 8'(inv), 8'(m_inv[k]));
    chk($sformatf("u%0d_round", k), 8'(rnd), 8'(m_rnd[k]));
    chk($sformatf("u%0d_over", k), 8'(over), 8'(m_over[k]));
    chk($sformatf("u%0d_winner", k), 8'(win), 8'(m_win[k]));
    chk($sformatf("u%0d_done", k), 8'(done), 8'(m_done[k]));
  endtask

  task automatic check_all();
    chk_inst(0, p1_0, p2_0, tie_0, inv_0, rnd_0, over_0, win_0, done_0);
    chk_inst(1, p1_1, p2_1, tie_1, inv_1, rnd_1, over_1, win_1, done_1);
  endtask

  task automatic check_ready();
    chk("u0_ready", 8'(u_if0.result_ready), 8'(ena && !m_over[0]));
    chk("u1_ready", 8'(u_if1.result_ready), 8'(ena && !m_over[1]));
  endtask

  // one clock of stimulus; entered and left at a falling edge
  task automatic step(input bit en, input bit v, input logic [1:0] r, input bit c);
    ena = en; clear = c;
    u_if0.result_valid = v; u_if0.result = r;
    u_if1.result_valid = v; u_if1.result = r;
    #1;
    check_ready();
    @(posedge clk);
    model_step(en, v, int'(r), c);
    @(negedge clk);
    check_all();
    if (v) begin
      txn++;
      $display("txn %0d: ena=%0b res=%b clr=%0b -> u0 p1=%0d p2=%0d tie=%0d inv=%0d rnd=%0d over=%0b win=%0d",
               txn, en, r, c, p1_0, p2_0, tie_0, inv_0, rnd_0, over_0, win_0);
    end
    u_if0.result_valid = 1'b0; u_if1.result_valid = 1'b0; clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0;
    u_if0.result_valid = 1'b0; u_if0.result = 2'b00;
    u_if1.result_valid = 1'b0; u_if1.result = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    #1;
    check_ready();

    // idle: nothing moves without strobes
    repeat (20) step(1, 0, 2'b00, 0);

    // P1 sweep
    repeat (3) step(1, 1, 2'b01, 0);
    chk("sweep_p1", 8'(p1_0), 8'd3);
    chk("sweep_round", 8'(rnd_0), 8'd3);
    chk("sweep_winner", 8'(win_0), 8'd1);
    chk("sweep_done", 8'(done_0), 8'd1);
    chk("sweep_ready", 8'(u_if0.result_ready), 8'd0);
    step(1, 1, 2'b10, 0);
    chk("sweep_ignored_p2", 8'(p2_0), 8'd0);
    chk("sweep_done_once", 8'(done_0), 8'd0);
    step(1, 0, 2'b00, 1);

    // mixed match
    step(1, 1, 2'b01, 0); step(1, 1, 2'b00, 0); step(1, 1, 2'b10, 0);
    step(1, 1, 2'b11, 0); step(1, 1, 2'b10, 0); step(1, 1, 2'b00, 0);
    chk("mixed_not_over_yet", 8'(over_0), 8'd0);
    step(1, 1, 2'b10, 0);
    chk("mixed_p1", 8'(p1_0), 8'd1);
    chk("mixed_p2", 8'(p2_0), 8'd3);
    chk("mixed_tie", 8'(tie_0), 8'd2);
    chk("mixed_inv", 8'(inv_0), 8'd1);
    chk("mixed_round", 8'(rnd_0), 8'd6);
    chk("mixed_winner", 8'(win_0), 8'd2);
    chk("t1_winner", 8'(win_1), 8'd1);
    step(1, 0, 2'b00, 1);

    // saturation
    repeat (20) step(1, 1, 2'b00, 0);
    chk("sat_tie", 8'(tie_0), 8'd15);
    chk("sat_round", 8'(rnd_0), 8'd15);
    chk("sat_still_play", 8'(over_0), 8'd0);
    repeat (17) step(1, 1, 2'b11, 0);
    chk("sat_inv", 8'(inv_0), 8'd15);

    // clear colliding with a verdict
    step(1, 1, 2'b01, 0);
    step(1, 1, 2'b01, 1);
    chk("collide_p1", 8'(p1_0), 8'd0);
    chk("collide_round", 8'(rnd_0), 8'd0);
    step(1, 1, 2'b01, 0);
    chk("after_clear_p1", 8'(p1_0), 8'd1);

    // ena gating
    step(0, 1, 2'b10, 0);
    step(0, 0, 2'b00, 1);
    chk("gate_p1", 8'(p1_0), 8'd1);
    chk("gate_p2", 8'(p2_0), 8'd0);

    // async reset mid-match, away from any clock edge
    step(1, 1, 2'b10, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_p2_now", 8'(p2_0), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1, 1, 2'b01, 0);
    chk("post_rst_winner", 8'(win_0), 8'd1);
    step(1, 0, 2'b00, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rps_match_scorer.md
# rps_match_scorer

Match-level scorekeeper for the stone-paper-scissors game; sits directly downstream of the round judge. It consumes one round verdict per strobe and tracks P1 wins, P2 wins, ties, invalid rounds and round count. It declares a match winner when either player reaches a configurable win target, then holds the result until cleared. All outputs are registered.

## Interface
- WIN_TARGET, 3: wins needed to take the match; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  block enable; low freezes all state and blocks acceptance.
- result_valid  in  1  single-cycle strobe, high in the cycle the judge's verdict is valid.
- result  in  2  verdict: 00 tie, 01 P1 wins, 10 P2 wins, 11 invalid.
- clear  in  1  synchronous new-match request; level, sampled every enabled cycle.
- result_ready  out  1  high when a verdict will be accepted this cycle.
- p1_score  out  4  P1 round wins.
- p2_score  out  4  P2 round wins.
- tie_count  out  4  tied rounds, saturating.
- invalid_count  out  4  invalid verdicts, saturating.
- round_no  out  4  scored rounds (wins + ties), saturating.
- match_over  out  1  high while in OVER.
- match_winner  out  2  00 none, 01 P1, 10 P2; valid when match_over=1.
- match_done  out  1  one-cycle pulse on entry to OVER.

## Operation
- States: IDLE (no round scored yet), PLAY (at least one round scored, no winner yet), OVER (winner declared).
- Accept condition: ena & result_valid & result_ready. result_ready = ena & (state != OVER).
- Per accepted verdict:
  - 01: p1_score+1, round_no+1.
  - 10: p2_score+1, round_no+1.
  - 00: tie_count+1, round_no+1.
  - 11: invalid_count+1 only; round_no unchanged; state unchanged.
- Counters tie_count, invalid_count and round_no saturate at 15; they never wrap.
- p1_score and p2_score cannot exceed WIN_TARGET.
- Transitions:
  - IDLE to PLAY on any accepted non-invalid verdict that does not end the match.
  - IDLE or PLAY to OVER when an accepted 01 makes p1_score == WIN_TARGET (match_winner = 01), or an accepted 10 makes p2_score == WIN_TARGET (match_winner = 10).
  - With WIN_TARGET=1, the first win goes IDLE to OVER directly.
- OVER: all verdicts are ignored, including invalid ones, and no counter changes. The block stays in OVER until clear.
- clear (with ena=1), from any state:
  - Next state is IDLE.
  - All counters, match_winner and match_over go to 0.
  - clear has priority over a simultaneous result_valid; that verdict is dropped and not counted.
- ena=0: no state change, no acceptance, clear ignored, match_done low. Outputs hold their values.

## Timing
- Reset values: state IDLE, all counters 0, match_over 0, match_winner 00, match_done 0. result_ready follows ena.
- Latency: a verdict accepted at edge T is visible on the counters after edge T (one cycle).
- match_over, match_winner and match_done assert after the same edge T as the deciding score. match_done is high for exactly one cycle.
- result_ready drops in the cycle after the winning verdict is accepted. The block never accepts two verdicts in one cycle.
- A strobe held high for N cycles is counted N times. The source must pulse it for one cycle only.
- clear at edge T: IDLE and zeroed outputs are visible after T. A verdict strobed at T+1 is accepted.
- Async reset mid-match forces reset values immediately, regardless of clk or ena.

## Test plan
- Reset then idle: outputs at reset values, result_ready=1 with ena=1. No change over 20 cycles without strobes.
- P1 sweep (WIN_TARGET=3): verdicts 01,01,01 → p1_score=3, round_no=3. match_done pulses once, match_winner=01, result_ready=0. A further 10 strobe is ignored (p2_score stays 0).
- Mixed match: 01,00,10,11,10,00,10 → p1=1, p2=3, tie=2, invalid=1, round_no=6, match_winner=10. OVER is entered after the 7th strobe.
- Saturation: 20 tie strobes → tie_count=15, round_no=15, state PLAY. 17 invalid strobes → invalid_count=15.
- clear collision: in PLAY, assert clear and result_valid=01 in the same cycle → all zero, IDLE, verdict not counted. A 01 on the next cycle gives p1_score=1.
- ena gating and reset mid-match: with ena=0, strobes and clear have no effect. rst_n pulsed low mid-match → immediate reset values, then a normal match completes.
